and_d6_slice: RTL and testbench
===============================

Name: and_d6_slice

Overview:
- 4-lane, 6-input bitwise AND slice for the fractcam match path.
- Each lane combines six partial-match bits (one per sub-table) into one final match-line bit.
- The andD6 wrapper tiles D/4 of these slices across the CAM depth.
- The slice registers its result and also provides a slice-level any-hit flag and the lowest-hit lane index, which feed priority encoding.

Parameters:
- W, 4, lanes per slice. Only the value 4 is supported; elaboration must fail with an error message for any other value.
- REG_OUT, 1. 1 = outputs registered (latency 1 cycle); 0 = outputs combinational (latency 0); clk and rst_n are then unused.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a..f this cycle.
- a  input  W  partial-match vector 0.
- b  input  W  partial-match vector 1.
- c  input  W  partial-match vector 2.
- d  input  W  partial-match vector 3.
- e  input  W  partial-match vector 4.
- f  input  W  partial-match vector 5.
- o  output  W  per-lane AND result.
- out_valid  output  1  o, hit and hit_idx are valid.
- hit  output  1  OR-reduction of o.
- hit_idx  output  2  index of the lowest-numbered set bit of o; 0 when hit=0.

Behaviour:
- Per lane i (0..3), combinational: m[i] = a[i] & b[i] & c[i] & d[i] & e[i] & f[i]. Lanes are fully independent; there is no cross-lane logic in m.
- Combinational reductions: h = |m; idx = lowest i with m[i]=1 (priority to lane 0), else 0.
- REG_OUT=1:
  - On each rising edge, o<=m, hit<=h, hit_idx<=idx, out_valid<=in_valid.
  - Data registers load every cycle regardless of in_valid; consumers qualify with out_valid.
  - Fixed latency of 1 cycle. There is no backpressure: one result per cycle, full throughput.
- REG_OUT=0: o=m, hit=h, hit_idx=idx, out_valid=in_valid, with zero latency.
- Reset (REG_OUT=1):
  - When rst_n=0, asynchronously o=0, hit=0, hit_idx=0, out_valid=0, without waiting for a clock edge.
  - Outputs hold these values while rst_n=0.
  - The first capture occurs on the first rising edge after rst_n deasserts.
  - Asserting rst_n mid-stream discards the in-flight result.
- Boundary cases:
  - all inputs 1111 -> o=1111, hit=1, hit_idx=0.
  - any single input 0000 -> o=0000, hit=0.
  - Only lane 3 fully set -> hit_idx=3.
  - An X on an unused (masked-by-zero) lane input must not affect other lanes.
- The AND is bitwise only. There are no width extension, arithmetic or signed semantics.
- Synthesis:
  - Each lane must map to a single 6-input LUT.
  - The instance carries a dont_touch attribute in the parent, so the slice must not depend on cross-boundary optimisation.

Test Plan:
- Reset: hold rst_n=0 with inputs all 1 and toggle clk -> o=0000, hit=0, hit_idx=0, out_valid=0. Release rst_n -> on the next edge o=1111, hit=1, hit_idx=0.
- Lane independence: a=1111, b=1011, c=1111, d=1110, e=1111, f=1111, in_valid=1 -> after 1 cycle o=1010, hit=1, hit_idx=1, out_valid=1.
- Priority: all inputs 1000 -> o=1000, hit_idx=3. Then all inputs 0110 -> o=0110, hit_idx=1 on the following cycle.
- Miss: a..e=1111, f=0000 -> o=0000, hit=0, hit_idx=0.
- Throughput/valid: apply 4 back-to-back vectors with in_valid pattern 1,0,1,1 -> outputs track the inputs one cycle later with out_valid pattern 1,0,1,1. Exhaustively sweep all 64 combinations per lane and compare o[i] to the reference AND.
- Async reset mid-stream: assert rst_n low between clock edges while o=1111 -> o drops to 0000 immediately. REG_OUT=0 build: o equals the AND in the same cycle.

Source files
------------

// File: rtl/and_d6_slice.sv
// Four-lane, six-input AND slice for the fractcam match path, with any-hit
// flag and lowest-hit lane index for the downstream priority encoder.
module and_d6_slice #(
    parameter int W       = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [W-1:0] f,
    output logic [W-1:0] o,
    output logic         out_valid,
    output logic         hit,
    output logic [1:0]   hit_idx
);

    if (W != 4) begin : g_bad_width
        $error("and_d6_slice: W must be 4, got %0d", W);
    end

    logic [W-1:0] w_m;
    logic         w_hit;
    logic [1:0]   w_idx;

    // Each lane sees exactly six inputs so it fits one 6-input LUT.
    assign w_m   = a & b & c & d & e & f;
    assign w_hit = |w_m;

    // Scan from the top lane down so the lowest set lane wins.
    always_comb begin
        w_idx = 2'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_m[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    // Valid-only stream: no ready/backpressure, one result per cycle. Data
    // loads every cycle; consumers must qualify o/hit/hit_idx with out_valid.
    if (REG_OUT) begin : g_reg
        logic [W-1:0] r_o;
        logic         r_valid;
        logic         r_hit;
        logic [1:0]   r_idx;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_o     <= '0;
                r_valid <= 1'b0;
                r_hit   <= 1'b0;
                r_idx   <= 2'd0;
            end else begin
                r_o     <= w_m;
                r_valid <= in_valid;
                r_hit   <= w_hit;
                r_idx   <= w_idx;
            end
        end

        assign o         = r_o;
        assign out_valid = r_valid;
        assign hit       = r_hit;
        assign hit_idx   = r_idx;
    end else begin : g_comb
        logic w_unused;
        assign w_unused  = clk ^ rst_n;
        assign o         = w_m;
        assign out_valid = in_valid;
        assign hit       = w_hit;
        assign hit_idx   = w_idx;
    end

endmodule

// File: tb/tb_and_d6_slice.sv
// Directed bench for and_d6_slice: registered and combinational builds side
// by side, driven from the same inputs.
module tb_and_d6_slice;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b, c, d, e, f;

    logic [3:0] o_r, o_c;
    logic       out_valid_r, out_valid_c;
    logic       hit_r, hit_c;
    logic [1:0] hit_idx_r, hit_idx_c;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q[$];

    and_d6_slice #(.W(4), .REG_OUT(1'b1)) u_dut_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .o         (o_r),
        .out_valid (out_valid_r),
        .hit       (hit_r),
        .hit_idx   (hit_idx_r)
    );

    and_d6_slice #(.W(4), .REG_OUT(1'b0)) u_dut_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .o         (o_c),
        .out_valid (out_valid_c),
        .hit       (hit_c),
        .hit_idx   (hit_idx_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                          input logic [3:0] vd, input logic [3:0] ve, input logic [3:0] vf,
                          input logic vld);
        a = va; b = vb; c = vc; d = vd; e = ve; f = vf;
        in_valid = vld;
    endtask

    function automatic logic [7:0] pack_reg();
        return {out_valid_r, hit_r, hit_idx_r, o_r};
    endfunction

    function automatic logic [7:0] pack_comb();
        return {out_valid_c, hit_c, hit_idx_c, o_c};
    endfunction

    // Drive at negedge, check the comb build at once and the registered build
    // one edge later. exp = {valid, hit, idx[1:0], o[3:0]}.
    task automatic vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] vc, input logic [3:0] vd, input logic [3:0] ve,
                       input logic [3:0] vf, input logic vld, input logic [7:0] exp);
        @(negedge clk);
        set_in(va, vb, vc, vd, ve, vf, vld);
        #1;
        check({tag, "_comb"}, pack_comb(), exp);
        @(posedge clk);
        #1;
        check({tag, "_reg"}, pack_reg(), exp);
    endtask

    initial begin
        logic [3:0] x_in;
        logic [5:0] p;
        logic [3:0] va, vb, vc, vd, ve, vf;
        logic [3:0] exp_o;
        logic [1:0] exp_idx;
        logic [7:0] exp_pk;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_in(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);

        // reset holds outputs low even with all-ones inputs and a running clock
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", pack_reg(), 8'h00);
        check("reset_comb_live", pack_comb(), 8'hCF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", pack_reg(), 8'hCF);

        // directed vectors
        vec("lane_indep", 4'b1111, 4'b1011, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 1'b1, 8'b1101_1010);
        vec("prio_lane3", 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 8'b1111_1000);
        vec("prio_lane1", 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 1'b1, 8'b1101_0110);
        vec("miss", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 8'b1000_0000);
        vec("all_ones", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 8'b1100_1111);
        vec("idle_data", 4'b0100, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 8'b0110_0100);

        // unknown on lane 2 of a, masked by b[2]=0, must not disturb other lanes
        x_in = 4'b1x11;
        vec("x_masked", x_in, 4'b1011, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 8'b1100_1011);

        // back-to-back stream with in_valid 1,0,1,1
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk);
            if (t > 0) begin
                if (exp_q.size() == 0) begin
                    check("stream_underflow", 8'h00, 8'hFF);
                end else begin
                    check($sformatf("stream_%0d", t - 1), pack_reg(), exp_q.pop_front());
                end
            end
            case (t)
                0: begin set_in(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0101, 1'b1); exp_q.push_back(8'hC5); end
                1: begin set_in(4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 1'b0); exp_q.push_back(8'h6C); end
                2: begin set_in(4'b0011, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1); exp_q.push_back(8'hC3); end
                3: begin set_in(4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1); exp_q.push_back(8'h80); end
                default: ;
            endcase
        end

        // every lane sees all 64 input combinations, lanes offset by 16
        for (int k = 0; k < 64; k++) begin
            exp_o = 4'h0;
            va = '0; vb = '0; vc = '0; vd = '0; ve = '0; vf = '0;
            for (int i = 0; i < 4; i++) begin
                p = 6'(k + 16 * i);
                va[i] = p[0]; vb[i] = p[1]; vc[i] = p[2];
                vd[i] = p[3]; ve[i] = p[4]; vf[i] = p[5];
                exp_o[i] = (p == 6'd63);
            end
            exp_idx = 2'd0;
            for (int i = 3; i >= 0; i--) if (exp_o[i]) exp_idx = 2'(i);
            exp_pk = {1'(k % 2), |exp_o, exp_idx, exp_o};
            vec($sformatf("sweep_%0d", k), va, vb, vc, vd, ve, vf, 1'(k % 2), exp_pk);
        end

        // async reset between edges drops outputs without a clock edge
        vec("pre_async", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 8'hCF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pack_reg(), 8'h00);
        @(posedge clk);
        #1;
        check("async_hold", pack_reg(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_recover", pack_reg(), 8'hCF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
